// File: rtl/regfile_wb_responder.sv
// Architectural integer register file: write-back handshake responder that commits
// once per request, pending-write scoreboard for decode stalls, and full-array export.
module regfile_wb_responder #(
    parameter int unsigned       XLEN    = 64,
    parameter logic [XLEN-1:0]   SP_INIT = '0,
    parameter bit                BYPASS  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    input  logic [4:0]               reg_write_addr,
    input  logic [XLEN-1:0]          reg_write_data,
    input  logic                     reg_write_en,
    output logic                     reg_write_done,
    input  logic                     issue_en,
    input  logic [4:0]               issue_rd,
    input  logic                     flush,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [31:0][XLEN-1:0]    registers
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [31:0]             busy_q, busy_d;
    logic [31:0][XLEN-1:0]   regs_q;
    logic                    commit;

    // Only the first cycle of a held request writes; ACK absorbs the rest.
    assign commit = (state_q == IDLE) && reg_write_en;

    // NOTE: every variable written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (reg_write_en) begin
                    state_d = ACK;
                    done_d  = 1'b1;
                end
            end
            ACK: begin
                if (!reg_write_en) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    // Issue is applied last so a newer producer (or one issued alongside flush) stays pending.
    always_comb begin
        busy_d = flush ? '0 : busy_q;
        if (commit) begin
            busy_d[reg_write_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the array is reset on purpose (sp needs SP_INIT), so it is built from flops, not RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else if (commit && (reg_write_addr != 5'd0)) begin
            regs_q[reg_write_addr] <= reg_write_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return '0;
        end
        if (BYPASS && commit && (reg_write_addr == addr)) begin
            return reg_write_data;
        end
        return regs_q[addr];
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    // Busy is deliberately not bypassed: the stall releases the cycle after commit.
    assign rs1_busy       = busy_q[rs1_addr];
    assign rs2_busy       = busy_q[rs2_addr];
    assign reg_write_done = done_q;
    assign registers      = regs_q;

endmodule

// File: tb/tb_regfile_wb_responder.sv
// Directed and randomized bench for regfile_wb_responder, checked against a
// behavioural model of the register file, handshake and scoreboard.
module tb_regfile_wb_responder;

    localparam logic [63:0] SP = 64'h8000;

    logic               clk = 1'b0;
    logic               reset;
    logic [4:0]         rs1_addr, rs2_addr;
    logic [63:0]        rs1_data, rs2_data;
    logic [4:0]         reg_write_addr;
    logic [63:0]        reg_write_data;
    logic               reg_write_en;
    logic               reg_write_done;
    logic               issue_en;
    logic [4:0]         issue_rd;
    logic               flush;
    logic               rs1_busy, rs2_busy;
    logic [31:0][63:0]  registers;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Model: register contents, pending bits, and "request already acknowledged".
    logic [63:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ack;

    always #5 clk = ~clk;

    regfile_wb_responder #(
        .XLEN    (64),
        .SP_INIT (SP),
        .BYPASS  (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .reg_write_addr (reg_write_addr),
        .reg_write_data (reg_write_data),
        .reg_write_en   (reg_write_en),
        .reg_write_done (reg_write_done),
        .issue_en       (issue_en),
        .issue_rd       (issue_rd),
        .flush          (flush),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .registers      (registers)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A read sees the write data only while a fresh request is being accepted.
    function automatic logic [63:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 64'h0;
        if (!m_ack && reg_write_en && reg_write_addr == a) return reg_write_data;
        return m_regs[a];
    endfunction

    task automatic compare_all();
        check("rs1_data", rs1_data, exp_read(rs1_addr));
        check("rs2_data", rs2_data, exp_read(rs2_addr));
        check("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr]));
        check("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr]));
        check("done", 64'(reg_write_done), 64'(m_ack));
        check("registers_rs1", registers[rs1_addr], m_regs[rs1_addr]);
    endtask

    task automatic update_model();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = (i == 2) ? SP : 64'h0;
                m_busy[i] = 1'b0;
            end
            m_ack = 1'b0;
        end else begin
            if (!m_ack && reg_write_en) begin
                if (reg_write_addr != 5'd0) m_regs[reg_write_addr] = reg_write_data;
                m_busy[reg_write_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end
            if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            m_ack = reg_write_en;
        end
    endtask

    task automatic cycle(input bit do_cmp = 1'b1);
        #1;
        if (do_cmp) compare_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; issue_en = 1'b0; issue_rd = 5'd0;
        reg_write_en = 1'b0; reg_write_addr = 5'd0; reg_write_data = 64'h0;
        rs1_addr = 5'd2; rs2_addr = 5'd1;
        cycle(1'b0);
        cycle();
        reset = 1'b0;

        // Reset state
        #1;
        for (int i = 0; i < 32; i++) check("reset_reg", registers[i], (i == 2) ? SP : 64'h0);
        check("reset_done", 64'(reg_write_done), 64'h0);
        check("reset_busy", 64'(rs1_busy), 64'h0);
        check("reset_sp_read", rs1_data, SP);

        // Single write with bypass in the commit cycle
        rs1_addr = 5'd5; reg_write_en = 1'b1; reg_write_addr = 5'd5; reg_write_data = 64'hDEAD_BEEF;
        #1 check("x5_bypass", rs1_data, 64'hDEAD_BEEF);
        cycle();
        reg_write_en = 1'b0;
        #1 check("x5_done", 64'(reg_write_done), 64'h1);
        check("x5_read", rs1_data, 64'hDEAD_BEEF);
        cycle();
        #1 check("x5_done_pulse", 64'(reg_write_done), 64'h0);
        cycle();

        // Held request: only the first value commits, done stays high
        rs1_addr = 5'd9; reg_write_en = 1'b1; reg_write_addr = 5'd9; reg_write_data = 64'h1234;
        cycle();
        reg_write_data = 64'h1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_done", 64'(reg_write_done), 64'h1);
            cycle();
        end
        reg_write_en = 1'b0;
        cycle();
        #1 check("hold_once", registers[9], 64'h1234);
        check("hold_idle", 64'(reg_write_done), 64'h0);
        cycle();

        // Write to x0 handshakes but changes nothing
        rs1_addr = 5'd0; reg_write_en = 1'b1; reg_write_addr = 5'd0; reg_write_data = 64'hFFFF;
        cycle();
        reg_write_en = 1'b0;
        #1 check("x0_done", 64'(reg_write_done), 64'h1);
        check("x0_read", rs1_data, 64'h0);
        check("x0_reg", registers[0], 64'h0);
        cycle();

        // Scoreboard: issue, commit two cycles later, then same-cycle issue+commit
        rs2_addr = 5'd7; issue_en = 1'b1; issue_rd = 5'd7;
        cycle();
        issue_en = 1'b0;
        #1 check("busy_after_issue", 64'(rs2_busy), 64'h1);
        cycle();
        reg_write_en = 1'b1; reg_write_addr = 5'd7; reg_write_data = 64'h42;
        #1 check("busy_commit_cycle", 64'(rs2_busy), 64'h1);
        cycle();
        reg_write_en = 1'b0;
        #1 check("busy_cleared", 64'(rs2_busy), 64'h0);
        cycle();
        issue_en = 1'b1; issue_rd = 5'd7;
        cycle();
        issue_en = 1'b1; reg_write_en = 1'b1; reg_write_data = 64'h43;
        cycle();
        issue_en = 1'b0; reg_write_en = 1'b0;
        #1 check("busy_issue_wins", 64'(rs2_busy), 64'h1);
        check("x7_second", registers[7], 64'h43);
        cycle();

        // Reset coinciding with a sampled write: no commit, done low
        rs1_addr = 5'd11; reg_write_en = 1'b1; reg_write_addr = 5'd11; reg_write_data = 64'hAAAA;
        reset = 1'b1;
        cycle();
        reset = 1'b0; reg_write_en = 1'b0;
        #1 check("rst_no_commit", registers[11], 64'h0);
        check("rst_done", 64'(reg_write_done), 64'h0);
        check("rst_busy", 64'(rs2_busy), 64'h0);
        cycle();

        // Flush clears three pending bits; flush+issue keeps only the issued bit
        for (int r = 3; r <= 5; r++) begin
            issue_en = 1'b1; issue_rd = 5'(r);
            cycle();
        end
        issue_en = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd5;
        #1 check("pre_flush", 64'({rs1_busy, rs2_busy}), 64'h3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1 check("flush_clear", 64'({rs1_busy, rs2_busy}), 64'h0);
        issue_en = 1'b1; issue_rd = 5'd3;
        cycle();
        flush = 1'b1; issue_rd = 5'd5;
        cycle();
        flush = 1'b0; issue_en = 1'b0;
        #1 check("flush_issue", 64'({rs1_busy, rs2_busy}), 64'h1);
        cycle();

        // Randomized traffic following the write-back protocol
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 63) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            issue_en = ($urandom_range(0, 2) == 0);
            issue_rd = 5'($urandom);
            if (reg_write_en) begin
                if (m_ack && $urandom_range(0, 3) != 0) reg_write_en = 1'b0;
                if ($urandom_range(0, 1) == 1) reg_write_data = {$urandom(), $urandom()};
            end else if ($urandom_range(0, 1) == 1) begin
                reg_write_en   = 1'b1;
                reg_write_addr = 5'($urandom);
                reg_write_data = {$urandom(), $urandom()};
            end
            rs1_addr = ($urandom_range(0, 1) == 1) ? reg_write_addr : 5'($urandom);
            rs2_addr = ($urandom_range(0, 1) == 1) ? issue_rd : 5'($urandom);
            cycle();
        end
        reset = 1'b0; reg_write_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
        cycle();
        #1;
        for (int i = 0; i < 32; i++) check("final_reg", registers[i], m_regs[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
